// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped data cache.
// Holds the controller state enum and line/word geometry.
package dcache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFFS_W         = 5;
    localparam int SEL_W          = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - OFFS_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bundles of the data cache controller.
// cpu: p1_* load/store port; mem: line fetch / write-back handshake.
interface dcache_cpu_if #(
    parameter int ADDR_W = 32
);
    logic              p1_req_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;

    modport master (
        output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_stall_o
    );
    modport slave (
        input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_stall_o
    );
endinterface

interface dcache_mem_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 256
);
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport master (
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );
    modport slave (
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: one combinational read port, one posedge
// write port. Only valid and dirty bits are reset (async, active-low).
module dcache_sram #(
    parameter int NUM_LINES = 32,
    parameter int TAG_W     = 22,
    parameter int LINE_BITS = 256,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 we,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 wr_dirty
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Ports: clk_i, rst_i (async low), cpu (p1_* slave), mem (line master).
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_cpu_if.slave cpu,
    dcache_mem_if.master mem
);

    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, NUM_LINES);
    localparam int LA_W  = ADDR_W - OFFS_W;

    state_t               state;
    logic                 en_q;
    logic                 wr_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LA_W-1:0]      miss_la;
    logic [LINE_BITS-1:0] fill_line;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [SEL_W-1:0]     sel;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic                 hit;
    logic                 store_hit;
    logic                 refill;
    logic                 we;
    logic [IDX_W-1:0]     wr_idx;
    logic [TAG_W-1:0]     wr_tag;
    logic [LINE_BITS-1:0] wr_line;
    logic [LINE_BITS-1:0] merged;

    assign req_idx = cpu.p1_addr_i[OFFS_W +: IDX_W];
    assign req_tag = cpu.p1_addr_i[ADDR_W-1 -: TAG_W];
    assign sel     = cpu.p1_addr_i[2 +: SEL_W];

    // While a miss is in flight the arrays are addressed by the latched
    // miss address, so a dropped request cannot corrupt the victim read.
    assign rd_idx = (state == IDLE) ? req_idx : miss_la[IDX_W-1:0];

    assign hit = cpu.p1_req_i & rd_valid
               & (rd_tag == req_tag) & (state == IDLE);
    assign store_hit = hit & cpu.p1_write_i;
    assign refill    = (state == REFILL);

    always_comb begin
        merged = rd_line;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (w == int'(sel)) begin
                merged[w*WORD_W +: WORD_W] = cpu.p1_data_i;
            end
        end
    end

    assign we      = store_hit | refill;
    assign wr_idx  = refill ? miss_la[IDX_W-1:0] : req_idx;
    assign wr_tag  = refill ? miss_la[LA_W-1 -: TAG_W] : req_tag;
    assign wr_line = refill ? fill_line : merged;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W),
        .LINE_BITS (LINE_BITS)
    ) u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (we),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_line  (wr_line),
        .wr_dirty (store_hit)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            miss_la <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu.p1_req_i && !hit) begin
                        miss_la <= cpu.p1_addr_i[ADDR_W-1:OFFS_W];
                        en_q    <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state  <= WRITEBACK;
                            wr_q   <= 1'b1;
                            addr_q <= {rd_tag, req_idx,
                                       {OFFS_W{1'b0}}};
                        end else begin
                            state  <= ALLOCATE;
                            wr_q   <= 1'b0;
                            addr_q <= {cpu.p1_addr_i[ADDR_W-1:OFFS_W],
                                       {OFFS_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    // Fetch request follows the write-back ack directly.
                    if (mem.mem_ack_i) begin
                        state  <= ALLOCATE;
                        wr_q   <= 1'b0;
                        addr_q <= {miss_la, {OFFS_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem.mem_ack_i) begin
                        state <= REFILL;
                        en_q  <= 1'b0;
                    end
                end
                REFILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem.mem_ack_i) begin
            fill_line <= mem.mem_data_i;
        end
    end

    assign mem.mem_enable_o = en_q;
    assign mem.mem_write_o  = wr_q;
    assign mem.mem_addr_o   = addr_q;
    assign mem.mem_data_o   = rd_line;

    assign cpu.p1_data_o  = rd_line[{sel, 5'd0} +: WORD_W];
    assign cpu.p1_stall_o = cpu.p1_req_i & ~hit;

endmodule
